// File: rtl/byte_word_packer.sv
// Packs a byte/valid stream into little-endian 32-bit words and queues them in a
// first-word-fall-through FIFO. Optional counters are enabled by BYTE_WORD_PACKER_STATS_EN.
module byte_word_packer #(
    parameter  int DEPTH = 4,
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    data_in,
    input  logic          valid_in,
    input  logic          flush,
    output logic [31:0]   out_data,
    output logic [3:0]    out_keep,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [LW-1:0] level,
    output logic          overflow
`ifdef BYTE_WORD_PACKER_STATS_EN
    ,
    output logic [15:0]   word_count,
    output logic [7:0]    drop_count
`endif
);

    localparam int PW = $clog2(DEPTH);

    // Packer state
    logic [1:0]    r_idx;
    logic [31:0]   r_partial;
    logic [3:0]    r_keep;

    // FIFO state
    logic [35:0]   r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          r_overflow;

    logic [31:0]   w_fill_data;
    logic [3:0]    w_fill_keep;
    logic          w_complete;
    logic          w_flush_push;
    logic          w_push;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_wr_en;
    logic          w_drop;
    logic [35:0]   w_head;

    // The same-cycle byte is merged first, so a flush always sees the post-byte word.
    always_comb begin
        // NOTE: defaults first so every path assigns every signal; no latch is inferred.
        w_fill_data = r_partial;
        w_fill_keep = r_keep;
        if (valid_in) begin
            w_fill_data[{r_idx, 3'b000} +: 8] = data_in;
            w_fill_keep[r_idx]                = 1'b1;
        end
    end

    assign w_complete   = valid_in && (r_idx == 2'd3);
    assign w_flush_push = flush && (valid_in || (r_idx != 2'd0));
    assign w_push       = w_complete || w_flush_push;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == LW'(DEPTH));
    assign w_pop   = !w_empty && out_ready;
    // A full FIFO still takes a word when the head leaves in the same cycle.
    assign w_wr_en = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && !w_wr_en;

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx     <= 2'd0;
            r_partial <= '0;
            r_keep    <= '0;
        end else if (w_push) begin
            r_idx     <= 2'd0;
            r_partial <= '0;
            r_keep    <= '0;
        end else if (valid_in) begin
            r_idx     <= r_idx + 2'd1;
            r_partial <= w_fill_data;
            r_keep    <= w_fill_keep;
        end
    end

    // NOTE: storage is not reset; out_valid gates it, so stale words are never visible.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= {w_fill_keep, w_fill_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_wr_en, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign w_head    = r_mem[r_rd_ptr];
    assign out_valid = !w_empty;
    assign out_data  = w_empty ? 32'h0 : w_head[31:0];
    assign out_keep  = w_empty ? 4'h0  : w_head[35:32];
    assign level     = r_level;
    assign overflow  = r_overflow;

`ifdef BYTE_WORD_PACKER_STATS_EN
    logic [15:0] r_word_count;
    logic [7:0]  r_drop_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word_count <= '0;
            r_drop_count <= '0;
        end else begin
            if (w_pop) begin
                r_word_count <= r_word_count + 16'd1;
            end
            if (w_drop && (r_drop_count != 8'hFF)) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

    assign word_count = r_word_count;
    assign drop_count = r_drop_count;
`endif

endmodule

// File: tb/tb_byte_word_packer.sv
// Directed bench for byte_word_packer: packing, flush, overflow, full+pop and reset.
module tb_byte_word_packer;

    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    data_in;
    logic          valid_in;
    logic          flush;
    logic [31:0]   out_data;
    logic [3:0]    out_keep;
    logic          out_valid;
    logic          out_ready;
    logic [LW-1:0] level;
    logic          overflow;
`ifdef BYTE_WORD_PACKER_STATS_EN
    logic [15:0]   word_count;
    logic [7:0]    drop_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_a [4];
    logic [31:0] exp_b [4];

    byte_word_packer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .flush     (flush),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .overflow  (overflow)
`ifdef BYTE_WORD_PACKER_STATS_EN
        ,
        .word_count(word_count),
        .drop_count(drop_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic f);
        data_in  = b;
        valid_in = 1'b1;
        flush    = f;
        tick();
        valid_in = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic idle(input logic f);
        valid_in = 1'b0;
        flush    = f;
        tick();
        flush    = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        exp_a[0] = 32'h53525150; exp_a[1] = 32'h57565554;
        exp_a[2] = 32'h5B5A5958; exp_a[3] = 32'h5F5E5D5C;
        exp_b[0] = 32'h87868584; exp_b[1] = 32'h8B8A8988;
        exp_b[2] = 32'h8F8E8D8C; exp_b[3] = 32'h93929190;

        data_in = 8'h00; valid_in = 1'b0; flush = 1'b0; out_ready = 1'b0;
        rst_n = 1'b0;
        #12;
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_level", 32'(level), 32'h0);
        check("rst_overflow", 32'(overflow), 32'h0);
        check("rst_data", out_data, 32'h0);
        check("rst_keep", 32'(out_keep), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full word with the consumer ready
        out_ready = 1'b1;
        send(8'h10, 1'b0);
        send(8'h20, 1'b0);
        send(8'h30, 1'b0);
        check("w1_not_yet", 32'(out_valid), 32'h0);
        send(8'h40, 1'b0);
        check("w1_valid", 32'(out_valid), 32'h1);
        check("w1_data", out_data, 32'h40302010);
        check("w1_keep", 32'(out_keep), 32'hF);
        check("w1_level", 32'(level), 32'h1);
        idle(1'b0);
        check("w1_drained", 32'(level), 32'h0);
        check("w1_valid_low", 32'(out_valid), 32'h0);

        // Flush of a two-byte partial word
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        idle(1'b1);
        check("fl_data", out_data, 32'h0000BBAA);
        check("fl_keep", 32'(out_keep), 32'h3);
        idle(1'b0);

        // Byte and flush in the same cycle at idx=2, then an empty flush
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'hCC, 1'b1);
        check("bf_data", out_data, 32'h00CC0201);
        check("bf_keep", 32'(out_keep), 32'h7);
        check("bf_level", 32'(level), 32'h1);
        idle(1'b0);
        idle(1'b1);
        check("empty_flush_valid", 32'(out_valid), 32'h0);
        check("empty_flush_level", 32'(level), 32'h0);

        // Flush with a byte that completes the word pushes exactly one word
        send(8'hE0, 1'b0);
        send(8'hE1, 1'b0);
        send(8'hE2, 1'b0);
        out_ready = 1'b0;
        send(8'hE3, 1'b1);
        check("cf_level", 32'(level), 32'h1);
        check("cf_data", out_data, 32'hE3E2E1E0);
        out_ready = 1'b1;
        idle(1'b0);
        check("cf_drained", 32'(level), 32'h0);

        // Stall and overflow: 20 bytes, 5th word dropped
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            send(8'(8'h50 + i), 1'b0);
            if (i == 7) check("stall_head_early", out_data, exp_a[0]);
        end
        check("ov_level", 32'(level), 32'h4);
        check("ov_flag", 32'(overflow), 32'h1);
        check("ov_head_stable", out_data, exp_a[0]);
        check("ov_keep_stable", 32'(out_keep), 32'hF);
`ifdef BYTE_WORD_PACKER_STATS_EN
        check("ov_drop_count", 32'(drop_count), 32'h1);
`endif
        idle(1'b0);
        check("ov_hold", out_data, exp_a[0]);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("drain_a%0d", k), out_data, exp_a[k]);
            idle(1'b0);
        end
        check("drain_a_level", 32'(level), 32'h0);
        check("drain_a_overflow_sticky", 32'(overflow), 32'h1);
`ifdef BYTE_WORD_PACKER_STATS_EN
        check("word_count", 32'(word_count), 32'h8);
`endif

        // Full FIFO with push and pop in the same cycle
        do_reset();
        check("rst2_overflow", 32'(overflow), 32'h0);
        out_ready = 1'b0;
        for (int i = 0; i < 19; i++) send(8'(8'h80 + i), 1'b0);
        check("fp_full", 32'(level), 32'h4);
        out_ready = 1'b1;
        send(8'h93, 1'b0);
        check("fp_level", 32'(level), 32'h4);
        check("fp_overflow", 32'(overflow), 32'h0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("drain_b%0d", k), out_data, exp_b[k]);
            idle(1'b0);
        end
        check("drain_b_level", 32'(level), 32'h0);

        // Reset mid-word with two words queued
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) send(8'(8'hC0 + i), 1'b0);
        check("pre_rst_level", 32'(level), 32'h2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'h0);
        check("mid_rst_level", 32'(level), 32'h0);
        check("mid_rst_overflow", 32'(overflow), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        check("post_rst_data", out_data, 32'h04030201);
        check("post_rst_keep", 32'(out_keep), 32'hF);
        check("post_rst_level", 32'(level), 32'h1);
        idle(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
